// File: rtl/acs_scheduler.sv
// Sequencer for a folded BMC/ACS array: sweeps all trellis state groups per symbol,
// assembles survivor decisions, writes survivor memory and schedules normalization.
// Optional macro SYM_COUNT_EN adds a 32-bit count of survivor writes (sym_count).
module acs_scheduler #(
  parameter int NUM_STATES = 64,
  parameter int PAR        = 8,
  parameter int TB_LEN     = 32,
  localparam int G         = NUM_STATES / PAR,
  localparam int GW        = (G > 1) ? $clog2(G) : 1,
  localparam int AW        = $clog2(TB_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready;
  // sym_ready is high only in IDLE and the source holds sym_valid/sym_in until then.
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic [1:0]            sym_in,
  output logic                  acs_en,
  output logic [GW-1:0]         acs_grp,
  output logic [1:0]            acs_rx_pair,
  output logic                  acs_norm,
  input  logic [PAR-1:0]        acs_dec,
  input  logic                  acs_norm_req,
  output logic                  surv_wr_en,
  output logic [AW-1:0]         surv_wr_addr,
  output logic [NUM_STATES-1:0] surv_wr_data,
  output logic                  tb_start,
  output logic                  busy
`ifdef SYM_COUNT_EN
  ,
  output logic [31:0]           sym_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(TB_LEN - 1);

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic [1:0]            rx_pair_q, rx_pair_d;
  logic [NUM_STATES-1:0] dec_q, dec_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  norm_sticky_q, norm_sticky_d;
  logic                  norm_q, norm_d;

  always_comb begin
    state_d       = state_q;
    grp_d         = grp_q;
    rx_pair_d     = rx_pair_q;
    dec_d         = dec_q;
    ptr_d         = ptr_q;
    norm_sticky_d = norm_sticky_q;
    norm_d        = norm_q;
    case (state_q)
      ST_IDLE: begin
        if (sym_valid) begin
          rx_pair_d = sym_in;
          grp_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        dec_d[int'(grp_q) * PAR +: PAR] = acs_dec;
        norm_sticky_d = norm_sticky_q | acs_norm_req;
        if (grp_q == GRP_LAST) state_d = ST_WRITE;
        else                   grp_d   = grp_q + GW'(1);
      end
      ST_WRITE: begin
        // Requests seen during this symbol apply to the whole of the next one.
        norm_d        = norm_sticky_q;
        norm_sticky_d = 1'b0;
        ptr_d         = ptr_q + AW'(1);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grp_q         <= '0;
      rx_pair_q     <= '0;
      dec_q         <= '0;
      ptr_q         <= '0;
      norm_sticky_q <= 1'b0;
      norm_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grp_q         <= grp_d;
      rx_pair_q     <= rx_pair_d;
      dec_q         <= dec_d;
      ptr_q         <= ptr_d;
      norm_sticky_q <= norm_sticky_d;
      norm_q        <= norm_d;
    end
  end

  assign sym_ready    = (state_q == ST_IDLE);
  assign acs_en       = (state_q == ST_RUN);
  assign acs_grp      = grp_q;
  assign acs_rx_pair  = rx_pair_q;
  assign acs_norm     = norm_q;
  assign surv_wr_en   = (state_q == ST_WRITE);
  assign surv_wr_addr = ptr_q;
  assign surv_wr_data = dec_q;
  assign tb_start     = (state_q == ST_WRITE) && (ptr_q == PTR_LAST);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_WRITE);

`ifdef SYM_COUNT_EN
  logic [31:0] sym_count_q, sym_count_d;

  always_comb begin
    sym_count_d = sym_count_q;
    if (state_q == ST_WRITE) sym_count_d = sym_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sym_count_q <= '0;
    else     sym_count_q <= sym_count_d;
  end

  assign sym_count = sym_count_q;
`endif

endmodule

// File: doc/acs_scheduler.md
Name: acs_scheduler

Overview:
- Sequencer for a folded branch-metric / add-compare-select (BMC/ACS) array in the Viterbi decoder.
- Accepts one received symbol pair at a time and sweeps the shared BMC/ACS datapath over all trellis states, PAR states per cycle.
- Assembles the per-state survivor decision bits into one word and writes it to survivor memory.
- Schedules path-metric normalization and signals traceback start every TB_LEN symbols.

Parameters:
- NUM_STATES, 64, number of trellis states; must be a multiple of PAR.
- PAR, 8, states processed per cycle by the shared datapath.
- TB_LEN, 32, survivor memory depth in symbols; power of two, at least 2.
- Derived: G = NUM_STATES/PAR; GW = clog2(G), minimum 1; AW = clog2(TB_LEN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sym_valid  in  1  input symbol pair valid.
- sym_ready  out  1  block can accept a symbol.
- sym_in  in  2  received hard-decision pair, {bit1, bit0}.
- acs_en  out  1  datapath update strobe for the addressed group.
- acs_grp  out  GW  state group index sent to the datapath.
- acs_rx_pair  out  2  latched symbol pair fed to the BMC units.
- acs_norm  out  1  datapath subtracts the normalization constant this symbol.
- acs_dec  in  PAR  survivor decision bits of group acs_grp, valid combinationally while acs_en=1.
- acs_norm_req  in  1  asserted by the datapath when any updated metric MSB is set.
- surv_wr_en  out  1  survivor memory write strobe.
- surv_wr_addr  out  AW  survivor write address.
- surv_wr_data  out  NUM_STATES  decision word; bit s is the decision for state s.
- tb_start  out  1  one-cycle pulse: survivor block of TB_LEN symbols complete.
- busy  out  1  high in the RUN and WRITE states.

Behaviour:
- Reset (async, active-high): state=IDLE; sym_ready=1; acs_en=0; acs_grp=0; acs_rx_pair=0; acs_norm=0; surv_wr_en=0; surv_wr_addr=0; surv_wr_data=0; tb_start=0; busy=0; write pointer=0; norm_sticky=0.
- Reset mid-sweep abandons the symbol. No write occurs for it. The pointer returns to 0.
- FSM, three states:
  - IDLE: sym_ready=1. On sym_valid, capture sym_in into acs_rx_pair, set grp=0, go to RUN.
  - RUN: sym_ready=0, acs_en=1, acs_grp=grp. Capture acs_dec into decision bits [grp*PAR +: PAR]. OR acs_norm_req into norm_sticky. If grp==G-1, go to WRITE; otherwise grp+1.
  - WRITE: surv_wr_en=1 for one cycle. surv_wr_addr=pointer. surv_wr_data=assembled word. Go to IDLE.
- Timing:
  - All outputs are registered, or decoded from registered state only.
  - Symbol accepted in cycle n: RUN occupies cycles n+1..n+G; the write occurs at cycle n+G+1.
  - Throughput is one symbol per G+2 cycles; sym_ready is not re-asserted before IDLE.
- Pointer: increments after each WRITE and wraps from TB_LEN-1 to 0. tb_start pulses in the WRITE cycle whose address is TB_LEN-1.
- Normalization:
  - At WRITE, the registered acs_norm is loaded from norm_sticky and norm_sticky is cleared.
  - acs_norm holds for the whole next symbol, through that symbol's WRITE.
  - A request raised in the last RUN cycle is still captured.
  - With back-to-back requests, acs_norm stays high.
- sym_valid outside IDLE is ignored; the upstream block holds it until sym_ready.
- Decision register bits for groups not yet swept keep their previous-symbol values until overwritten.

Optional Feature:
- Macro SYM_COUNT_EN.
- Defined: adds output sym_count (out, 32). Reset value 0. Increments by 1 in each WRITE cycle and wraps at 2^32-1 to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then symbol 2'b10 with acs_dec=8'hA5 for all groups -> acs_grp steps 0..7; surv_wr_en at cycle n+9; surv_wr_data=64'hA5A5A5A5A5A5A5A5; surv_wr_addr=0; acs_rx_pair=2'b10.
- 32 back-to-back symbols -> addresses 0..31; tb_start high only on the address-31 write; the 33rd symbol writes address 0.
- acs_norm_req=1 only in RUN grp=7 of symbol k -> acs_norm=0 during symbol k and 1 during symbol k+1. No request in k+1 -> acs_norm=0 during symbol k+2.
- sym_valid held high continuously -> sym_ready high exactly one cycle per 10; no symbol lost or duplicated; busy low only in IDLE.
- Assert rst at grp=4 -> all outputs take reset values immediately; no write; the next symbol writes address 0.
- With SYM_COUNT_EN defined, 5 symbols -> sym_count=5 after the fifth WRITE; preload the counter to 32'hFFFFFFFF and do one WRITE -> 0.
